// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback, counts retired instructions.
// 2-5 cycles per instruction; FETCH, MEM_RD and MEM_WR hold their strobes until mem_ready_i.
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                branch_ne_o,
    output logic [1:0]          pc_src_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                mem_to_reg_o,
    output logic                link_o,
    output logic [1:0]          reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                jalfor_o,
    output logic                illegal_op_o,
    output logic [CNT_W-1:0]    retired_count_o
);
    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(6'b110000);
    localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(6'b110001);
    localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(6'b110010);
    localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(6'b110011);
    localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(6'b110100);
    localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(6'b110101);
    localparam logic [OPCODE_W-1:0] OP_J      = OPCODE_W'(6'b110110);
    localparam logic [OPCODE_W-1:0] OP_JAL    = OPCODE_W'(6'b110111);
    localparam logic [OPCODE_W-1:0] OP_JALFOR = OPCODE_W'(6'b111000);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(3'b010);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
    } state_t;

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                retire;
    logic                op_legal;

    always_comb begin
        op_legal = 1'b0;
        case (opcode_i)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_J, OP_JAL, OP_JALFOR: op_legal = 1'b1;
            default:                          op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                    OP_R:                      state_d = S_EXEC_R;
                    OP_ADDI:                   state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE:            state_d = S_BRANCH;
                    OP_J, OP_JAL, OP_JALFOR:   state_d = S_JUMP;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default:    state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode of state; reset forces every control line low so an aborted access writes nothing.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_src_o        = 2'b00;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        link_o          = 1'b0;
        reg_dst_o       = 2'b00;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = ALU_ADD;
        jalfor_o        = 1'b0;
        illegal_op_o    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o  = 2'b11;
                    illegal_op_o = !op_legal;
                end
                S_MEM_ADDR, S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_FN;
                end
                S_ALU_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 2'b01;
                end
                S_BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = ALU_SUB;
                    pc_write_cond_o = 1'b1;
                    pc_src_o        = 2'b01;
                    branch_ne_o     = (op_q == OP_BNE);
                end
                S_JUMP: begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 2'b10;
                    if (op_q == OP_JAL || op_q == OP_JALFOR) begin
                        reg_write_o = 1'b1;
                        link_o      = 1'b1;
                    end
                    if (op_q == OP_JALFOR) begin
                        reg_dst_o = 2'b10;
                        jalfor_o  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign retired_count_o = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-instruction effect summaries compared against a table model.
module tb_multicycle_control;
    localparam logic [5:0] OP_R      = 6'b110000;
    localparam logic [5:0] OP_LW     = 6'b110001;
    localparam logic [5:0] OP_SW     = 6'b110010;
    localparam logic [5:0] OP_BEQ    = 6'b110011;
    localparam logic [5:0] OP_BNE    = 6'b110100;
    localparam logic [5:0] OP_ADDI   = 6'b110101;
    localparam logic [5:0] OP_J      = 6'b110110;
    localparam logic [5:0] OP_JAL    = 6'b110111;
    localparam logic [5:0] OP_JALFOR = 6'b111000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    always #5 clk = ~clk;

    logic a_pc_write, a_pc_write_cond, a_branch_ne, a_i_or_d, a_mem_read, a_mem_write, a_ir_write;
    logic a_mem_to_reg, a_link, a_reg_write, a_alu_src_a, a_jalfor, a_illegal_op;
    logic [1:0] a_pc_src, a_reg_dst, a_alu_src_b;
    logic [2:0] a_alu_op;
    logic [3:0] a_retired;
    logic b_pc_write, b_pc_write_cond, b_branch_ne, b_i_or_d, b_mem_read, b_mem_write, b_ir_write;
    logic b_mem_to_reg, b_link, b_reg_write, b_alu_src_a, b_jalfor, b_illegal_op;
    logic [1:0] b_pc_src, b_reg_dst, b_alu_src_b;
    logic [2:0] b_alu_op;
    logic [31:0] b_retired;

    multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .CNT_W(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(a_pc_write), .pc_write_cond_o(a_pc_write_cond), .branch_ne_o(a_branch_ne),
        .pc_src_o(a_pc_src), .i_or_d_o(a_i_or_d), .mem_read_o(a_mem_read), .mem_write_o(a_mem_write),
        .ir_write_o(a_ir_write), .mem_to_reg_o(a_mem_to_reg), .link_o(a_link), .reg_dst_o(a_reg_dst),
        .reg_write_o(a_reg_write), .alu_src_a_o(a_alu_src_a), .alu_src_b_o(a_alu_src_b),
        .alu_op_o(a_alu_op), .jalfor_o(a_jalfor), .illegal_op_o(a_illegal_op),
        .retired_count_o(a_retired));

    multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .CNT_W(32)) dut_b (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
        .pc_write_o(b_pc_write), .pc_write_cond_o(b_pc_write_cond), .branch_ne_o(b_branch_ne),
        .pc_src_o(b_pc_src), .i_or_d_o(b_i_or_d), .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
        .ir_write_o(b_ir_write), .mem_to_reg_o(b_mem_to_reg), .link_o(b_link), .reg_dst_o(b_reg_dst),
        .reg_write_o(b_reg_write), .alu_src_a_o(b_alu_src_a), .alu_src_b_o(b_alu_src_b),
        .alu_op_o(b_alu_op), .jalfor_o(b_jalfor), .illegal_op_o(b_illegal_op),
        .retired_count_o(b_retired));

    // Effect summary of one instruction, from its first FETCH cycle up to the next one.
    typedef struct {
        int cycles; int n_ir; int n_regw; logic [1:0] dst; int n_link; int n_m2r;
        int n_memw; int n_rd_d; int n_pcw; int n_pcwc; int n_bne; int n_ill; int n_jf;
        int n_fn; int n_sub; int n_srca; int n_imm; int n_bad; int unsigned ret;
    } sum_t;

    sum_t        sb[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int unsigned exp_ret = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the architectural effects each opcode must have, independent of state encoding.
    function automatic sum_t model(input logic [5:0] op, input int fw, input int mw, input int unsigned ret_in);
        sum_t e;
        bit   legal;
        e = '{default: 0};
        e.n_ir = 1;
        e.n_pcw = 1;
        legal = 1'b1;
        case (op)
            OP_LW:     begin e.cycles = 5 + mw; e.n_regw = 1; e.dst = 2'b00; e.n_m2r = 1;
                             e.n_rd_d = mw + 1; e.n_srca = 1; e.n_imm = 1; end
            OP_SW:     begin e.cycles = 4 + mw; e.n_memw = mw + 1; e.n_srca = 1; e.n_imm = 1; end
            OP_R:      begin e.cycles = 4; e.n_regw = 1; e.dst = 2'b01; e.n_fn = 1; e.n_srca = 1; end
            OP_ADDI:   begin e.cycles = 4; e.n_regw = 1; e.dst = 2'b01; e.n_srca = 1; e.n_imm = 1; end
            OP_BEQ:    begin e.cycles = 3; e.n_pcwc = 1; e.n_sub = 1; e.n_srca = 1; end
            OP_BNE:    begin e.cycles = 3; e.n_pcwc = 1; e.n_sub = 1; e.n_srca = 1; e.n_bne = 1; end
            OP_J:      begin e.cycles = 3; e.n_pcw = 2; end
            OP_JAL:    begin e.cycles = 3; e.n_pcw = 2; e.n_regw = 1; e.dst = 2'b00; e.n_link = 1; end
            OP_JALFOR: begin e.cycles = 3; e.n_pcw = 2; e.n_regw = 1; e.dst = 2'b10; e.n_link = 1;
                             e.n_jf = 1; end
            default:   begin e.cycles = 2; e.n_ill = 1; legal = 1'b0; end
        endcase
        e.cycles += fw;
        e.ret = legal ? ret_in + 1 : ret_in;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    task automatic cyc(input logic mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic [5:0] post);
        sum_t e;
        e = model(op, fw, mw, exp_ret);
        exp_ret = e.ret;
        sb.push_back(e);
        repeat (fw) cyc(1'b0, rop());
        cyc(1'b1, rop());
        cyc(rbit(), op);
        case (op)
            OP_LW: begin
                cyc(rbit(), post);
                repeat (mw) cyc(1'b0, post);
                cyc(1'b1, post);
                cyc(rbit(), post);
            end
            OP_SW: begin
                cyc(rbit(), post);
                repeat (mw) cyc(1'b0, post);
                cyc(1'b1, post);
            end
            OP_R, OP_ADDI: repeat (2) cyc(rbit(), post);
            OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JALFOR: cyc(rbit(), post);
            default: ;
        endcase
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc(1'b1, OP_LW);
        rst = 1'b0;
        exp_ret = 0;
    endtask

    // Monitor: detects instruction boundaries at the first FETCH cycle and closes the previous summary.
    sum_t acc;
    logic in_instr = 1'b0;
    logic prev_fetch = 1'b0;
    logic post_rst = 1'b0;
    logic fetch;

    task automatic close_instr();
        sum_t e;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty_at_close", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check("cycles", 64'(acc.cycles), 64'(e.cycles));
            check("ir_write_pulses", 64'(acc.n_ir), 64'(e.n_ir));
            check("reg_write_cycles", 64'(acc.n_regw), 64'(e.n_regw));
            check("reg_dst", 64'(acc.dst), 64'(e.dst));
            check("link_cycles", 64'(acc.n_link), 64'(e.n_link));
            check("mem_to_reg_cycles", 64'(acc.n_m2r), 64'(e.n_m2r));
            check("mem_write_cycles", 64'(acc.n_memw), 64'(e.n_memw));
            check("data_read_cycles", 64'(acc.n_rd_d), 64'(e.n_rd_d));
            check("pc_write_cycles", 64'(acc.n_pcw), 64'(e.n_pcw));
            check("pc_write_cond_cycles", 64'(acc.n_pcwc), 64'(e.n_pcwc));
            check("branch_ne_cycles", 64'(acc.n_bne), 64'(e.n_bne));
            check("illegal_op_pulses", 64'(acc.n_ill), 64'(e.n_ill));
            check("jalfor_cycles", 64'(acc.n_jf), 64'(e.n_jf));
            check("alu_fn_cycles", 64'(acc.n_fn), 64'(e.n_fn));
            check("alu_sub_cycles", 64'(acc.n_sub), 64'(e.n_sub));
            check("alu_src_a_cycles", 64'(acc.n_srca), 64'(e.n_srca));
            check("alu_src_b_imm_cycles", 64'(acc.n_imm), 64'(e.n_imm));
            check("protocol_violations", 64'(acc.n_bad), 64'(e.n_bad));
            check("retired_count_w4", 64'(a_retired), 64'(e.ret[3:0]));
            check("retired_count_w32", 64'(b_retired), 64'(e.ret));
        end
    endtask

    always @(negedge clk) begin
        fetch = a_mem_read && !a_i_or_d;
        if (rst) begin
            check("reset_outputs_w4", 64'({a_pc_write, a_pc_write_cond, a_branch_ne, a_pc_src, a_i_or_d,
                  a_mem_read, a_mem_write, a_ir_write, a_mem_to_reg, a_link, a_reg_dst, a_reg_write,
                  a_alu_src_a, a_alu_src_b, a_alu_op, a_jalfor, a_illegal_op, a_retired}), 64'd0);
            check("reset_outputs_w32", 64'({b_pc_write, b_pc_write_cond, b_branch_ne, b_pc_src, b_i_or_d,
                  b_mem_read, b_mem_write, b_ir_write, b_mem_to_reg, b_link, b_reg_dst, b_reg_write,
                  b_alu_src_a, b_alu_src_b, b_alu_op, b_jalfor, b_illegal_op, b_retired}), 64'd0);
            in_instr   = 1'b0;
            prev_fetch = 1'b0;
            post_rst   = 1'b1;
        end else begin
            if (post_rst) begin
                check("fetch_after_reset", 64'({a_mem_read, a_i_or_d, a_alu_src_b}), 64'({1'b1, 1'b0, 2'b01}));
                post_rst = 1'b0;
            end
            if (fetch && !prev_fetch) begin
                if (in_instr) close_instr();
                acc = '{default: 0};
                in_instr = 1'b1;
            end
            if (in_instr) begin
                acc.cycles++;
                if (a_ir_write) acc.n_ir++;
                if (a_reg_write) begin acc.n_regw++; acc.dst = a_reg_dst; end
                if (a_link) acc.n_link++;
                if (a_mem_to_reg) acc.n_m2r++;
                if (a_mem_write) acc.n_memw++;
                if (a_mem_read && a_i_or_d) acc.n_rd_d++;
                if (a_pc_write) acc.n_pcw++;
                if (a_pc_write_cond) acc.n_pcwc++;
                if (a_branch_ne) acc.n_bne++;
                if (a_illegal_op) acc.n_ill++;
                if (a_jalfor) acc.n_jf++;
                if (a_alu_op == 3'b010) acc.n_fn++;
                if (a_alu_op == 3'b001) acc.n_sub++;
                if (a_alu_src_a) acc.n_srca++;
                if (a_alu_src_b == 2'b10) acc.n_imm++;
                if (a_mem_read && a_mem_write) acc.n_bad++;
                if (a_ir_write && !fetch) acc.n_bad++;
                if (a_pc_write && a_pc_src != (fetch ? 2'b00 : 2'b10)) acc.n_bad++;
                if (a_pc_write_cond && a_pc_src != 2'b01) acc.n_bad++;
                if (a_mem_write && !a_i_or_d) acc.n_bad++;
            end
            prev_fetch = fetch;
        end
    end

    logic [5:0] seq [9];
    logic [5:0] pick;

    initial begin
        seq = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JALFOR};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // lw aborted by reset while waiting in MEM_RD, with mem_ready high during reset
        cyc(1'b1, rop());
        cyc(1'b1, OP_LW);
        cyc(1'b0, rop());
        cyc(1'b0, rop());
        cyc(1'b0, rop());
        pulse_reset(3);

        foreach (seq[i]) run_instr(seq[i], 0, 0, rop());
        run_instr(OP_LW, 2, 3, rop());
        run_instr(6'b000000, 0, 0, rop());
        run_instr(OP_R, 0, 0, OP_LW);
        run_instr(OP_SW, 1, 2, OP_LW);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k == 9) pick = 6'($urandom_range(0, 47));
            else        pick = seq[k];
            run_instr(pick, $urandom_range(0, 3), $urandom_range(0, 3), rop());
        end

        // close the last instruction before restarting the counter
        cyc(1'b0, rop());
        pulse_reset(2);
        repeat (17) run_instr(OP_J, 1, 0, rop());

        repeat (3) cyc(1'b0, rop());
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control FSM that supersedes the single-cycle opcode decoder for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and stalls on a memory ready handshake. It also counts retired instructions and flags illegal opcodes. It sits between the instruction register (opcode source) and the shared-memory multi-cycle datapath (PC, IR, ALU, ALUOut, MDR, register file muxes).

## Interface
- OPCODE_W, 6, opcode field width
- ALU_OP_W, 3, width of alu_op to ALU control
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  IR opcode field, sampled in DECODE
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition met
- branch_ne  out  1  branch condition is "not zero" (bne) instead of "zero" (beq)
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory request strobes
- ir_write  out  1  load IR
- mem_to_reg  out  1  register write data from MDR
- link  out  1  register write data is PC (jal/jalfor)
- reg_dst  out  2  same encoding as single-cycle unit (00 rt, 01 rd, 10 jalfor dest)
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 PC, 1 reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  ALU_OP_W  000 add, 001 sub, 010 function code
- jalfor  out  1  jalfor instruction active
- illegal_op  out  1  one-cycle pulse on unknown opcode
- retired_count  out  CNT_W  legal instructions completed, wraps

## Operation
- Opcodes: 110000 R, 110001 lw, 110010 sw, 110011 beq, 110100 bne, 110101 addi, 110110 j, 110111 jal, 111000 jalfor.
- op_q: opcode registered in DECODE. All later states decode op_q, not opcode.
- Outputs are Moore decodes of state, except where noted. Any output not listed for a state is 0.
- FETCH: mem_read, alu_src_b=01, alu_op=000. ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEM_ADDR
  - R -> EXEC_R
  - addi -> EXEC_I
  - beq/bne -> BRANCH
  - j/jal/jalfor -> JUMP
  - other -> FETCH with illegal_op=1 (treated as nop, not retired)
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Go to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read, i_or_d. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write, mem_to_reg, reg_dst=00. Retire, then go to FETCH.
- MEM_WR: mem_write, i_or_d. Wait for mem_ready, then retire and go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010. Go to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000. Go to ALU_WB.
- ALU_WB: reg_write, reg_dst=01. Retire, then go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond, pc_src=01, branch_ne=(op_q==bne). Retire, then go to FETCH.
- JUMP: pc_write, pc_src=10.
  - jal: reg_write=1, link=1, reg_dst=00.
  - jalfor: reg_write=1, link=1, reg_dst=10, jalfor=1.
  - Retire, then go to FETCH.
- retired_count increments by 1 in each retiring cycle and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset: while rst=1, all outputs are forced to 0, and next state=FETCH, op_q=0, retired_count=0. FETCH is first active in the cycle after rst falls.
- rst has priority over every transition, including a mid-instruction mem_ready. An aborted instruction is not retired and makes no write.
- Cycle counts with zero wait (mem_ready=1 on first request cycle):
  - lw 5
  - sw, R, addi 4
  - beq, bne, j, jal, jalfor 3
  - illegal 2
- Each cycle of mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle. Strobes stay asserted and i_or_d is stable throughout the wait.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Never assert mem_read and mem_write together.
- Never assert ir_write outside FETCH.
- reg_write lasts exactly one cycle per writing instruction.

## Test plan
- Reset held 3 cycles, in mid-MEM_RD -> all outputs 0 during reset, retired_count=0. The cycle after rst falls: FETCH with mem_read=1.
- Sequence R, addi, lw, sw, beq, bne, j, jal, jalfor with mem_ready=1 -> per-instruction cycle counts 4,4,5,4,3,3,3,3,3 and retired_count=9.
  - Check branch_ne=1 only for bne; reg_dst 01/01/00/10 on the R/addi/lw/jalfor writes; link=1 only for jal/jalfor.
- lw with mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEM_RD -> 10 total cycles. mem_read and i_or_d held stable during waits; ir_write pulses once.
- Opcode 000000 -> illegal_op pulse in DECODE, no reg_write/mem_write/pc_write beyond fetch increment, retired_count unchanged.
- CNT_W=4, 17 single-cycle-wait j instructions -> retired_count wraps to 1.
- Opcode input changed to lw after DECODE of an R-type -> R sequence completes unchanged (op_q used).
